accel_cmd_engine: RTL and testbench

Parametrised successor to the fixed two-instance stream command master: one block serving C_NUM_CHAN independent datamover command/status channel pairs (MM2S or S2MM) from one paged set/get register bus. Each channel has its own command queue, auto-incrementing tag, status collection, completion counter and error capture. Per-channel completion/error events are OR-ed into a single level irq. Sits between axi4_lite_slave and the datamover(s) at accelerator top level.

---
 rtl/accel_cmd_pkg.sv | 34 +++
 rtl/accel_cmd_chan.sv | 116 +++++++++++
 rtl/accel_cmd_engine.sv | 70 +++++++
 tb/tb_accel_cmd_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/accel_cmd_pkg.sv
// accel_cmd_pkg: shared register offsets, field positions and helpers for accel_cmd_engine
package accel_cmd_pkg;
  localparam int CMD_W = 72;
  localparam int STS_W = 8;
  localparam int TAG_W = 4;
  localparam int BTT_W = 23;
  localparam logic [7:0] REG_ADDR = 8'h00;
  localparam logic [7:0] REG_LEN  = 8'h04;
  localparam logic [7:0] REG_CTRL = 8'h08;
  localparam logic [7:0] REG_STAT = 8'h0C;
  localparam logic [7:0] REG_DONE = 8'h10;
  localparam logic [7:0] REG_LAST = 8'h14;
  localparam int CMD_INCR     = 23;
  localparam int CMD_EOF      = 30;
  localparam int CMD_DRR      = 31;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_TAG_LSB  = 64;
  localparam int STS_OK       = 7;
  localparam int CTRL_CLR     = 31;
  function automatic logic [CMD_W-1:0] make_cmd(input logic [31:0] addr, input logic [BTT_W-1:0] btt,
                                                input logic [TAG_W-1:0] tag, input logic eof, input logic drr);
    make_cmd = '0;
    make_cmd[BTT_W-1:0] = btt;
    make_cmd[CMD_INCR] = 1'b1;
    make_cmd[CMD_EOF] = eof;
    make_cmd[CMD_DRR] = drr;
    make_cmd[CMD_ADDR_LSB +: 32] = addr;
    make_cmd[CMD_TAG_LSB +: TAG_W] = tag;
  endfunction
  // status is bad when OKAY is clear or any of the INTERR/DECERR/SLVERR bits is set
  function automatic logic sts_err(input logic [STS_W-1:0] s);
    sts_err = !s[STS_OK] || |s[6:4];
  endfunction
endpackage

// File: rtl/accel_cmd_chan.sv
// accel_cmd_chan: one datamover command/status channel with queue, tag, counters and registers
// Ports: clk/rst; wr/wr_off/wr_data register write; rd/rd_off/rd_data register read;
// cmd_* command stream out; sts_* status stream in; irq channel interrupt level.
// Optional ACCEL_CMD_TIMEOUT_EN adds a 24b busy watchdog reported in STAT[13].
module accel_cmd_chan
  import accel_cmd_pkg::*;
#(
  parameter int C_CMD_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [7:0]       wr_off,
  input  logic [31:0]      wr_data,
  input  logic             rd,
  input  logic [7:0]       rd_off,
  output logic [31:0]      rd_data,
  output logic             cmd_tvalid,
  input  logic             cmd_tready,
  output logic [CMD_W-1:0] cmd_tdata,
  input  logic             sts_tvalid,
  output logic             sts_tready,
  input  logic [STS_W-1:0] sts_tdata,
  output logic             irq
);
  localparam int AW = $clog2(C_CMD_DEPTH);
  logic [CMD_W-1:0] mem [C_CMD_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [AW+1:0] outs;
  logic [31:0] addr_q;
  logic [BTT_W-1:0] btt_q;
  logic irq_en, eof, drr, ovf, err, pend, rdy, tmo;
  logic [15:0] done;
  logic [7:0] last;
  logic [TAG_W-1:0] tag;
  logic full, empty, busy, wr_len, clr, pop, push, acc;
  assign full = cnt == (AW+1)'(C_CMD_DEPTH);
  assign empty = cnt == '0;
  assign busy = outs != '0;
  assign wr_len = wr && wr_off == REG_LEN;
  assign clr = wr && wr_off == REG_CTRL && wr_data[CTRL_CLR];
  assign cmd_tvalid = !empty && !rst;
  assign cmd_tdata = mem[rp];
  assign sts_tready = rdy && !rst;
  assign pop = cmd_tvalid && cmd_tready;
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign push = wr_len && (!full || pop);
  assign acc = sts_tvalid && sts_tready;
  assign irq = pend || (irq_en && (err || tmo));
  always_ff @(posedge clk)
    if (push) mem[wp] <= make_cmd(addr_q, wr_data[BTT_W-1:0], tag, eof, drr);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      outs <= '0;
      addr_q <= '0;
      btt_q <= '0;
      {drr, eof, irq_en} <= '0;
      tag <= '0;
      done <= '0;
      last <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
      pend <= 1'b0;
      rdy <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (wr && wr_off == REG_ADDR) addr_q <= wr_data;
      if (wr_len) btt_q <= wr_data[BTT_W-1:0];
      if (wr && wr_off == REG_CTRL) {drr, eof, irq_en} <= wr_data[2:0];
      if (push) begin
        wp <= wp + 1'b1;
        tag <= tag + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (pop && !acc && !(&outs)) outs <= outs + 1'b1;
      else if (acc && !pop && busy) outs <= outs - 1'b1;
      if (acc) last <= sts_tdata;
      if (clr) done <= '0;
      else if (acc && !(&done)) done <= done + 1'b1;
      if (clr) ovf <= 1'b0;
      else if (wr_len && !push) ovf <= 1'b1;
      if (clr) err <= 1'b0;
      else if (acc && sts_err(sts_tdata)) err <= 1'b1;
      if (clr) pend <= 1'b0;
      else if (acc && irq_en) pend <= 1'b1;
      else if (rd && rd_off == REG_LAST) pend <= 1'b0;
    end
  end
`ifdef ACCEL_CMD_TIMEOUT_EN
  logic [23:0] wd;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
      tmo <= 1'b0;
    end else begin
      wd <= (acc || !busy) ? '0 : (&wd) ? wd : wd + 1'b1;
      if (clr) tmo <= 1'b0;
      else if (&wd) tmo <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif
  always_comb
    rd_data = rd_off == REG_ADDR ? addr_q :
              rd_off == REG_LEN  ? {9'b0, btt_q} :
              rd_off == REG_CTRL ? {29'b0, drr, eof, irq_en} :
              rd_off == REG_STAT ? {18'b0, tmo, err, ovf, busy, empty, full, 8'(cnt)} :
              rd_off == REG_DONE ? {16'b0, done} :
              rd_off == REG_LAST ? {24'b0, last} : 32'b0;
endmodule

// File: rtl/accel_cmd_engine.sv
// accel_cmd_engine: paged set/get register front end for C_NUM_CHAN datamover command channels
// Ports: clk/rst; set_* register write; get_* register read (get_data combinational);
// m_axis_cmd_* per-channel command streams; s_axis_sts_* per-channel status streams; irq OR of channels.
// Optional ACCEL_CMD_TIMEOUT_EN enables per-channel busy watchdogs.
module accel_cmd_engine
  import accel_cmd_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_CHAN = 4,
  parameter int C_CMD_DEPTH = 8,
  parameter int C_PAGEWIDTH = 16,
  parameter int C_M_AXIS_CMD_DATA_WIDTH = 72,
  parameter int C_M_AXIS_STS_DATA_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 set_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                 set_data,
  input  logic                                          set_stb,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 get_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                 get_data,
  input  logic                                          get_stb,
  output logic [C_NUM_CHAN-1:0]                         m_axis_cmd_tvalid,
  input  logic [C_NUM_CHAN-1:0]                         m_axis_cmd_tready,
  output logic [C_M_AXIS_CMD_DATA_WIDTH*C_NUM_CHAN-1:0] m_axis_cmd_tdata,
  input  logic [C_NUM_CHAN-1:0]                         s_axis_sts_tvalid,
  output logic [C_NUM_CHAN-1:0]                         s_axis_sts_tready,
  input  logic [C_M_AXIS_STS_DATA_WIDTH*C_NUM_CHAN-1:0] s_axis_sts_tdata,
  output logic                                          irq
);
  localparam int SW = $clog2(C_NUM_CHAN);
  logic [3:0] wsel, rsel;
  logic [31:0] rd [C_NUM_CHAN];
  logic [C_NUM_CHAN-1:0] irq_v;
  logic unused_addr;
  assign unused_addr = ^{set_addr, get_addr};
  if (SW == 0) begin : g_one
    assign wsel = 4'd0;
    assign rsel = 4'd0;
  end else begin : g_many
    assign wsel = 4'(set_addr[C_PAGEWIDTH +: SW]);
    assign rsel = 4'(get_addr[C_PAGEWIDTH +: SW]);
  end
  // a page index with no matching channel selects nothing: writes drop, reads return 0
  for (genvar i = 0; i < C_NUM_CHAN; i++) begin : g_ch
    accel_cmd_chan #(.C_CMD_DEPTH(C_CMD_DEPTH)) u_chan (
      .clk(clk),
      .rst(rst),
      .wr(set_stb && wsel == 4'(i)),
      .wr_off(set_addr[7:0]),
      .wr_data(set_data[31:0]),
      .rd(get_stb && rsel == 4'(i)),
      .rd_off(get_addr[7:0]),
      .rd_data(rd[i]),
      .cmd_tvalid(m_axis_cmd_tvalid[i]),
      .cmd_tready(m_axis_cmd_tready[i]),
      .cmd_tdata(m_axis_cmd_tdata[C_M_AXIS_CMD_DATA_WIDTH*i +: CMD_W]),
      .sts_tvalid(s_axis_sts_tvalid[i]),
      .sts_tready(s_axis_sts_tready[i]),
      .sts_tdata(s_axis_sts_tdata[C_M_AXIS_STS_DATA_WIDTH*i +: STS_W]),
      .irq(irq_v[i])
    );
  end
  always_comb begin
    get_data = '0;
    for (int c = 0; c < C_NUM_CHAN; c++) get_data = rsel == 4'(c) ? rd[c] : get_data;
  end
  assign irq = |irq_v;
endmodule

// File: tb/tb_accel_cmd_engine.sv
// tb_accel_cmd_engine: directed self-checking bench for accel_cmd_engine
module tb_accel_cmd_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] set_addr = '0, set_data = '0, get_addr = '0;
  logic set_stb = 1'b0, get_stb = 1'b0;
  logic [31:0] get_data;
  logic [3:0] cmd_tvalid, cmd_tready, sts_tvalid, sts_tready;
  logic [287:0] cmd_tdata;
  logic [31:0] sts_tdata;
  logic irq;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  accel_cmd_engine dut (
    .clk(clk), .rst(rst),
    .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
    .get_addr(get_addr), .get_data(get_data), .get_stb(get_stb),
    .m_axis_cmd_tvalid(cmd_tvalid), .m_axis_cmd_tready(cmd_tready), .m_axis_cmd_tdata(cmd_tdata),
    .s_axis_sts_tvalid(sts_tvalid), .s_axis_sts_tready(sts_tready), .s_axis_sts_tdata(sts_tdata),
    .irq(irq)
  );
  function automatic logic [31:0] a(input int ch, input logic [7:0] off);
    a = (32'(ch) << 16) | {24'b0, off};
  endfunction
  task automatic wr(input int ch, input logic [7:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    set_addr = a(ch, off); set_data = d; set_stb = 1'b1;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask
  task automatic rd(input int ch, input logic [7:0] off, output logic [31:0] d);
    get_addr = a(ch, off); #1;
    d = get_data;
  endtask
  task automatic rd_clr(input int ch, input logic [7:0] off);
    @(posedge clk); #1;
    get_addr = a(ch, off); get_stb = 1'b1;
    @(posedge clk); #1;
    get_stb = 1'b0;
  endtask
  task automatic sts(input int ch, input logic [7:0] s);
    @(posedge clk); #1;
    sts_tvalid[ch] = 1'b1; sts_tdata[8*ch +: 8] = s;
    @(posedge clk); #1;
    sts_tvalid[ch] = 1'b0;
  endtask
  task automatic pop(input int ch, input int n);
    @(posedge clk); #1;
    cmd_tready[ch] = 1'b1;
    repeat (n) @(posedge clk);
    #1 cmd_tready[ch] = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (cmd_tvalid !== 4'h0) begin fails++; $display("FAIL rst_tvalid got %h exp 0", cmd_tvalid); end
    tests++; if (sts_tready !== 4'h0) begin fails++; $display("FAIL rst_tready got %h exp 0", sts_tready); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got %b exp 0", irq); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (sts_tready !== 4'hF) begin fails++; $display("FAIL post_rst_tready got %h exp f", sts_tready); end
    rd(0, 8'h0C, d);
    tests++; if (d !== 32'h200) begin fails++; $display("FAIL rst_stat got %h exp 200", d); end
    rd(0, 8'h10, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_done got %h exp 0", d); end
  endtask
  task automatic test_cmd_format;
    logic [31:0] d;
    wr(0, 8'h08, 32'h4);
    wr(0, 8'h00, 32'h1000_0000);
    wr(0, 8'h04, 32'h100);
    tests++; if (cmd_tvalid !== 4'b0001) begin fails++; $display("FAIL fmt_tvalid got %b exp 0001", cmd_tvalid); end
    tests++; if (cmd_tdata[71:0] !== 72'h00_1000_0000_8080_0100) begin fails++; $display("FAIL fmt_tdata got %h exp 0010000000808000100", cmd_tdata[71:0]); end
    rd(0, 8'h00, d);
    tests++; if (d !== 32'h1000_0000) begin fails++; $display("FAIL fmt_addr_rd got %h exp 10000000", d); end
    pop(0, 1);
    tests++; if (cmd_tvalid[0] !== 1'b0) begin fails++; $display("FAIL fmt_popped got %b exp 0", cmd_tvalid[0]); end
    rd(0, 8'h0C, d);
    tests++; if (d !== 32'h600) begin fails++; $display("FAIL fmt_stat_busy got %h exp 600", d); end
    wr(0, 8'h08, 32'h0);
  endtask
  task automatic test_overflow;
    logic [31:0] d;
    int n;
    wr(2, 8'h00, 32'h2000);
    for (int k = 0; k < 9; k++) wr(2, 8'h04, 32'(k + 1));
    rd(2, 8'h0C, d);
    tests++; if (d !== 32'h908) begin fails++; $display("FAIL ovf_stat got %h exp 908", d); end
    rd(2, 8'h04, d);
    tests++; if (d !== 32'h9) begin fails++; $display("FAIL ovf_len_rd got %h exp 9", d); end
    n = 0;
    cmd_tready[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (cmd_tvalid[2]) begin
        tests++; if (cmd_tdata[144+64 +: 4] !== 4'(n)) begin fails++; $display("FAIL ovf_tag got %h exp %h", cmd_tdata[144+64 +: 4], 4'(n)); end
        tests++; if (cmd_tdata[144 +: 23] !== 23'(n + 1)) begin fails++; $display("FAIL ovf_btt got %h exp %h", cmd_tdata[144 +: 23], 23'(n + 1)); end
        n++;
      end
      @(posedge clk); #1;
    end
    cmd_tready[2] = 1'b0;
    tests++; if (n !== 8) begin fails++; $display("FAIL ovf_count got %0d exp 8", n); end
    rd(2, 8'h0C, d);
    tests++; if (d !== 32'hE00) begin fails++; $display("FAIL ovf_stat_drain got %h exp e00", d); end
  endtask
  task automatic test_status_irq;
    logic [31:0] d;
    wr(1, 8'h08, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL sts_irq_pre got %b exp 0", irq); end
    sts(1, 8'h80);
    rd(1, 8'h10, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL sts_done got %h exp 1", d); end
    rd(1, 8'h14, d);
    tests++; if (d !== 32'h80) begin fails++; $display("FAIL sts_last got %h exp 80", d); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL sts_irq got %b exp 1", irq); end
    rd_clr(1, 8'h14);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL sts_irq_clr got %b exp 0", irq); end
  endtask
  task automatic test_error;
    logic [31:0] d;
    wr(3, 8'h08, 32'h1);
    sts(3, 8'h20);
    rd(3, 8'h0C, d);
    tests++; if (d[12] !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", d[12]); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL err_irq got %b exp 1", irq); end
    rd_clr(3, 8'h14);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL err_irq_hold got %b exp 1", irq); end
    wr(3, 8'h08, 32'h8000_0000);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL err_irq_clr got %b exp 0", irq); end
    rd(3, 8'h0C, d);
    tests++; if (d !== 32'h200) begin fails++; $display("FAIL err_stat_clr got %h exp 200", d); end
    rd(3, 8'h10, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL err_done_clr got %h exp 0", d); end
  endtask
  task automatic test_tag_wrap;
    cmd_tready[1] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wr(1, 8'h04, 32'(k));
      tests++; if (cmd_tvalid[1] !== 1'b1 || cmd_tdata[72+64 +: 4] !== 4'(k % 16))
        begin fails++; $display("FAIL wrap_tag[%0d] got v=%b tag=%h exp v=1 tag=%h", k, cmd_tvalid[1], cmd_tdata[72+64 +: 4], 4'(k % 16)); end
    end
    @(posedge clk); #1;
    cmd_tready[1] = 1'b0;
    tests++; if (cmd_tvalid[1] !== 1'b0) begin fails++; $display("FAIL wrap_drain got %b exp 0", cmd_tvalid[1]); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] d;
    wr(0, 8'h08, 32'h1);
    sts(0, 8'h80);
    for (int k = 0; k < 5; k++) wr(0, 8'h04, 32'h40);
    pop(0, 2);
    rd(0, 8'h0C, d);
    tests++; if (d !== 32'h403) begin fails++; $display("FAIL mid_stat_pre got %h exp 403", d); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL mid_irq_pre got %b exp 1", irq); end
    @(posedge clk); #1;
    rst = 1'b1; cmd_tready = 4'hF; sts_tvalid = 4'hF;
    #1;
    tests++; if (cmd_tvalid !== 4'h0) begin fails++; $display("FAIL mid_rst_tvalid got %h exp 0", cmd_tvalid); end
    tests++; if (sts_tready !== 4'h0) begin fails++; $display("FAIL mid_rst_tready got %h exp 0", sts_tready); end
    @(posedge clk); #1;
    rst = 1'b0; cmd_tready = 4'h0; sts_tvalid = 4'h0;
    tests++; if (cmd_tvalid !== 4'h0) begin fails++; $display("FAIL mid_tvalid got %h exp 0", cmd_tvalid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got %b exp 0", irq); end
    rd(0, 8'h0C, d);
    tests++; if (d !== 32'h200) begin fails++; $display("FAIL mid_stat0 got %h exp 200", d); end
    rd(0, 8'h10, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL mid_done0 got %h exp 0", d); end
    rd(2, 8'h0C, d);
    tests++; if (d !== 32'h200) begin fails++; $display("FAIL mid_stat2 got %h exp 200", d); end
  endtask
  initial begin
    cmd_tready = '0; sts_tvalid = '0; sts_tdata = '0;
    test_reset;
    test_cmd_format;
    test_overflow;
    test_status_irq;
    test_error;
    test_tag_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
